// File: rtl/uart_pkg.sv
// UART transmit framer shared definitions.
// State encoding, line levels and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  function automatic logic par_bit(
    input logic typ,
    input logic red
  );
    par_bit = red;
    if (typ == PAR_ODD) par_bit = ~red;
    else if (typ == PAR_EVEN) par_bit = red;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART framer.
// Full/empty come from the registered count only.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push)
            - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: FIFO-buffered words serialised as
// start | data LSB first | optional parity | 1 or 2 stop bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int PRESCALE_W = 6
) (
  input  logic                  UART_CLK,
  input  logic                  Reset,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [WIDTH-1:0]      Data_in,
  input  logic                  Data_valid,
  output logic                  Ready,
  output logic                  Fifo_empty,
  output logic                  Tx_out,
  output logic                  Busy,
  output logic                  Frame_done,
  output logic                  Overflow
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [PRESCALE_W-1:0] ONE =
    PRESCALE_W'(1);

  tx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  paren_q, paren_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q, ovf_d;

  logic                  full, empty, pop;
  logic [WIDTH-1:0]      rdata;
  logic [PRESCALE_W-1:0] ps_in;
  logic                  bit_end;
  logic                  start_frame;

  uart_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (UART_CLK),
    .rst_n   (Reset),
    .push_i  (Data_valid),
    .wdata_i (Data_in),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ps_in   = (Prescale == '0) ? ONE : Prescale;
  assign bit_end = (pcnt_q == ONE);

  assign Ready      = ~full;
  assign Fifo_empty = empty;
  assign Tx_out     = tx_q;
  assign Busy       = (state_q != S_IDLE);
  assign Overflow   = ovf_q;
  assign Frame_done = (state_q == S_STOP) && bit_end
                   && (!stop2_q || bcnt_q == BW'(1));

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    ps_d        = ps_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    paren_d     = paren_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    ovf_d       = Data_valid & full;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state_q != S_IDLE && !bit_end)
      pcnt_d = pcnt_q - ONE;

    unique case (state_q)
      S_IDLE: begin
        if (!empty) start_frame = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          pcnt_d  = ps_q;
          bcnt_d  = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          pcnt_d = ps_q;
          if (bcnt_q == BW'(WIDTH - 1)) begin
            bcnt_d  = '0;
            state_d = paren_q ? S_PARITY : S_STOP;
            tx_d    = paren_q ? par_q : STOP_BIT;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bcnt_d  = bcnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          pcnt_d  = ps_q;
          bcnt_d  = '0;
          tx_d    = STOP_BIT;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && bcnt_q == '0) begin
            bcnt_d = BW'(1);
            pcnt_d = ps_q;
          end else if (!empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = STOP_BIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Config is captured here so mid-frame changes are ignored.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = S_START;
      tx_d    = START_BIT;
      ps_d    = ps_in;
      pcnt_d  = ps_in;
      shift_d = rdata;
      par_d   = par_bit(PAR_TYP, ^rdata);
      paren_d = PAR_EN;
      stop2_d = STOP2;
    end
  end

  always_ff @(posedge UART_CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pcnt_q  <= ONE;
      ps_q    <= ONE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      paren_q <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= STOP_BIT;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ps_q    <= ps_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      paren_q <= paren_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer.
// Frames are reconstructed bit by bit from Tx_out.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       STOP2 = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic       Data_valid = 1'b0;
  logic       Ready, Fifo_empty, Tx_out;
  logic       Busy, Frame_done, Overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int fd_last = 0;
  int fd_prev = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (Overflow === 1'b1) ovf_cnt++;
    if (Frame_done === 1'b1) begin
      fd_prev = fd_last;
      fd_last = cyc;
    end
  end

  uart_tx_framer dut (
    .UART_CLK   (clk),
    .Reset      (rst_n),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .Data_in    (Data_in),
    .Data_valid (Data_valid),
    .Ready      (Ready),
    .Fifo_empty (Fifo_empty),
    .Tx_out     (Tx_out),
    .Busy       (Busy),
    .Frame_done (Frame_done),
    .Overflow   (Overflow)
  );

  task automatic set_cfg(
    input logic [5:0] ps,
    input logic pe,
    input logic pt,
    input logic s2
  );
    Prescale = ps;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    STOP2    = s2;
  endtask

  task automatic push(input logic [7:0] w);
    @(posedge clk);
    #1 Data_valid = 1'b1;
    Data_in = w;
    @(posedge clk);
    #1 Data_valid = 1'b0;
  endtask

  task automatic push2(
    input logic [7:0] a,
    input logic [7:0] b
  );
    @(posedge clk);
    #1 Data_valid = 1'b1;
    Data_in = a;
    @(posedge clk);
    #1 Data_in = b;
    @(posedge clk);
    #1 Data_valid = 1'b0;
  endtask

  // Waits for a start bit, then samples every cycle of the frame.
  task automatic capture(
    input  int          ps,
    input  int          nb,
    output logic [15:0] bits,
    output int          done_c,
    output int          gap,
    output bit          busy_low,
    output bit          glitch,
    output bit          found
  );
    int k;
    bits = '0;
    done_c = 0;
    gap = 0;
    busy_low = 0;
    glitch = 0;
    found = 0;
    while (!found && gap < 300) begin
      @(negedge clk);
      if (Tx_out === 1'b0) found = 1;
      else gap++;
    end
    if (found) begin
      for (int c = 0; c < nb * ps; c++) begin
        if (c > 0) @(negedge clk);
        k = c / ps;
        if (c % ps == 0) bits[k] = Tx_out;
        else if (Tx_out !== bits[k]) glitch = 1;
        if (Busy !== 1'b1) busy_low = 1;
        if (Frame_done === 1'b1 && done_c == 0)
          done_c = c + 1;
      end
    end
  endtask

  task automatic test_reset;
    logic [5:0] o;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = {Tx_out, Busy, Ready, Fifo_empty,
         Frame_done, Overflow};
    checks++;
    if (o !== 6'b101100) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=101100", o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1 busy=0",
               Tx_out, Busy);
    end
  endtask

  task automatic test_even_parity;
    logic [15:0] b;
    int dc, gp;
    bit bl, gl, f;
    set_cfg(6'd8, 1'b1, 1'b0, 1'b0);
    push(8'hAA);
    capture(8, 11, b, dc, gp, bl, gl, f);
    checks++;
    if (!f) begin
      failures++;
      $display("FAIL t1_start got=no_start exp=start");
    end
    // 0,0,1,0,1,0,1,0,1,0,1 LSB-first in time
    checks++;
    if (b !== 16'h0554) begin
      failures++;
      $display("FAIL t1_bits got=%h exp=0554", b);
    end
    checks++;
    if (dc != 88) begin
      failures++;
      $display("FAIL t1_done_cycle got=%0d exp=88", dc);
    end
    checks++;
    if (gl || bl) begin
      failures++;
      $display("FAIL t1_stable got glitch=%0b busy_low=%0b exp 0 0",
               gl, bl);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Tx_out !== 1'b1) begin
      failures++;
      $display("FAIL t1_idle_after got busy=%b tx=%b exp 0 1",
               Busy, Tx_out);
    end
  endtask

  task automatic test_parity_type;
    logic [15:0] b;
    int dc, gp;
    bit bl, gl, f;
    set_cfg(6'd8, 1'b1, 1'b1, 1'b0);
    push(8'h08);
    capture(8, 11, b, dc, gp, bl, gl, f);
    checks++;
    if (b !== 16'h0410) begin
      failures++;
      $display("FAIL t2_odd_bits got=%h exp=0410", b);
    end
    set_cfg(6'd8, 1'b1, 1'b0, 1'b0);
    push(8'h08);
    capture(8, 11, b, dc, gp, bl, gl, f);
    checks++;
    if (b !== 16'h0610) begin
      failures++;
      $display("FAIL t2_even_bits got=%h exp=0610", b);
    end
  endtask

  task automatic test_two_stop;
    logic [15:0] b;
    int dc, gp;
    bit bl, gl, f;
    set_cfg(6'd4, 1'b0, 1'b0, 1'b1);
    push(8'h3C);
    capture(4, 11, b, dc, gp, bl, gl, f);
    checks++;
    if (b !== 16'h0678) begin
      failures++;
      $display("FAIL t3_bits got=%h exp=0678", b);
    end
    checks++;
    if (dc != 44 || gl) begin
      failures++;
      $display("FAIL t3_length got done=%0d glitch=%0b exp 44 0",
               dc, gl);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL t3_idle got busy=%b exp=0", Busy);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] got [17];
    logic        rdy [18];
    logic [7:0]  w;
    int          ovf0;
    bit          all_found;
    all_found = 1;
    set_cfg(6'd8, 1'b0, 1'b0, 1'b0);
    ovf0 = ovf_cnt;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          @(posedge clk);
          #1 Data_valid = 1'b1;
          Data_in = 8'(i * 13 + 7);
          @(negedge clk);
          rdy[i] = Ready;
        end
        @(posedge clk);
        #1 Data_valid = 1'b0;
      end
      begin
        logic [15:0] b;
        int dc, gp;
        bit bl, gl, f;
        for (int i = 0; i < 17; i++) begin
          capture(8, 10, b, dc, gp, bl, gl, f);
          got[i] = b;
          if (!f) all_found = 0;
        end
      end
    join
    checks++;
    if (rdy[16] !== 1'b1 || rdy[17] !== 1'b0) begin
      failures++;
      $display("FAIL t4_ready got r16=%b r17=%b exp 1 0",
               rdy[16], rdy[17]);
    end
    checks++;
    if (ovf_cnt - ovf0 != 1) begin
      failures++;
      $display("FAIL t4_overflow got=%0d exp=1",
               ovf_cnt - ovf0);
    end
    checks++;
    if (!all_found) begin
      failures++;
      $display("FAIL t4_frames got=missing exp=17");
    end
    for (int i = 0; i < 17; i++) begin
      w = 8'(i * 13 + 7);
      checks++;
      if (got[i] !== {6'b0, 1'b1, w, 1'b0}) begin
        failures++;
        $display("FAIL t4_frame%0d got=%h exp=%h", i,
                 got[i], {6'b0, 1'b1, w, 1'b0});
      end
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL t4_drained got busy=%b empty=%b exp 0 1",
               Busy, Fifo_empty);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] b1, b2;
    int dc1, dc2, g1, g2;
    bit bl1, bl2, gl1, gl2, f1, f2;
    set_cfg(6'd8, 1'b1, 1'b0, 1'b0);
    push2(8'h5A, 8'hC3);
    capture(8, 11, b1, dc1, g1, bl1, gl1, f1);
    capture(8, 11, b2, dc2, g2, bl2, gl2, f2);
    checks++;
    if (b1 !== 16'h04B4 || b2 !== 16'h0586) begin
      failures++;
      $display("FAIL t5_bits got=%h,%h exp=04b4,0586", b1, b2);
    end
    checks++;
    if (g2 != 0 || !f2) begin
      failures++;
      $display("FAIL t5_gap got=%0d exp=0", g2);
    end
    checks++;
    if (bl1 || bl2) begin
      failures++;
      $display("FAIL t5_busy got busy_drop=1 exp=0");
    end
    @(posedge clk);
    #1;
    checks++;
    if (fd_last - fd_prev != 88) begin
      failures++;
      $display("FAIL t5_done_spacing got=%0d exp=88",
               fd_last - fd_prev);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] b;
    int dc, gp;
    bit bl, gl, f, hi, seen;
    set_cfg(6'd0, 1'b0, 1'b0, 1'b0);
    push2(8'h55, 8'h0F);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Tx_out === 1'b0) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL t6_start got=no_start exp=start");
    end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Tx_out !== 1'b1 || Busy !== 1'b0 ||
        Fifo_empty !== 1'b1 || Ready !== 1'b1) begin
      failures++;
      $display("FAIL t6_async got tx=%b busy=%b empty=%b exp 1 0 1",
               Tx_out, Busy, Fifo_empty);
    end
    #1 rst_n = 1'b1;
    hi = 1;
    repeat (30) begin
      @(negedge clk);
      if (Tx_out !== 1'b1) hi = 0;
    end
    checks++;
    if (!hi) begin
      failures++;
      $display("FAIL t6_quiet got=tx_low exp=tx_high");
    end
    push(8'h55);
    capture(1, 10, b, dc, gp, bl, gl, f);
    checks++;
    if (b !== 16'h02AA || dc != 10) begin
      failures++;
      $display("FAIL t6_ps0 got bits=%h done=%0d exp 02aa 10",
               b, dc);
    end
  endtask

  initial begin
    test_reset;
    test_even_parity;
    test_parity_type;
    test_two_stop;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
